// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser, tick-based debouncer, press/long/release strobes and press duration latch
module key_debounce #(
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int DUR_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    output logic             key_level,
    output logic             key_press,
    output logic             key_release,
    output logic             key_long,
    output logic [DUR_W-1:0] press_ticks,
    output logic             press_valid
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(DEBOUNCE_TICKS);
    localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
    localparam logic [DUR_W-1:0]  LONG_VAL  = DUR_W'(LONG_TICKS);
    // A long threshold beyond the saturation value can never be hit.
    localparam bit LONG_REACHABLE = (longint'(LONG_TICKS) <= ((longint'(1) << DUR_W) - 1));

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              s1;
    logic              key_s;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_nxt;
    logic [STAB_W-1:0] stab_inc;
    logic [DUR_W-1:0]  hold_cnt;
    logic [DUR_W-1:0]  hold_nxt;
    logic [DUR_W-1:0]  hold_inc;
    logic              press_nxt;
    logic              release_nxt;
    logic              long_nxt;
    logic [DUR_W-1:0]  ticks_nxt;
    logic              valid_nxt;

    assign tick      = (tick_cnt == TICK_LAST);
    assign stab_inc  = stab_cnt + STAB_W'(1);
    assign hold_inc  = (hold_cnt == DUR_MAX) ? hold_cnt : hold_cnt + DUR_W'(1);
    assign key_level = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            key_s    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            s1       <= key;
            key_s    <= s1;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stab_cnt    <= '0;
            hold_cnt    <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            press_ticks <= '0;
            press_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            stab_cnt    <= stab_nxt;
            hold_cnt    <= hold_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
            press_ticks <= ticks_nxt;
            press_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stab_nxt    = stab_cnt;
        hold_nxt    = hold_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        ticks_nxt   = press_ticks;
        valid_nxt   = press_valid;

        // The hold timer keeps running through release bounce, so long detection lives outside the case.
        if (key_level && tick) begin
            hold_nxt = hold_inc;
            long_nxt = LONG_REACHABLE && (hold_cnt != DUR_MAX) && (hold_inc == LONG_VAL);
        end

        case (state)
            IDLE: begin
                if (key_s) begin
                    state_nxt = PRESS_WAIT;
                    stab_nxt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_nxt = IDLE;
                    stab_nxt  = '0;
                end else if (tick) begin
                    if (stab_inc == STAB_DONE) begin
                        state_nxt = HELD;
                        stab_nxt  = '0;
                        hold_nxt  = '0;
                        press_nxt = 1'b1;
                    end else begin
                        stab_nxt = stab_inc;
                    end
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_nxt = RELEASE_WAIT;
                    stab_nxt  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_nxt = HELD;
                    stab_nxt  = '0;
                end else if (tick) begin
                    if (stab_inc == STAB_DONE) begin
                        state_nxt   = IDLE;
                        stab_nxt    = '0;
                        release_nxt = 1'b1;
                        ticks_nxt   = hold_inc;
                        valid_nxt   = 1'b1;
                    end else begin
                        stab_nxt = stab_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                stab_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce with a run-length reference model
module tb_key_debounce;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LT = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key;
    logic          key_level;
    logic          key_press;
    logic          key_release;
    logic          key_long;
    logic [DW-1:0] press_ticks;
    logic          press_valid;

    always #5 clk = ~clk;

    key_debounce #(
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DB),
        .LONG_TICKS    (LT),
        .DUR_W         (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .press_ticks(press_ticks),
        .press_valid(press_valid)
    );

    typedef struct {
        logic k;
        int   cycles;
        int   np;
        int   nr;
        int   nl;
        logic lvl_end;
        int   min_pt;
    } vec_t;

    vec_t tbl[7];

    int checks = 0;
    int errors = 0;

    // Reference model: edges counted from reset release; ticks fall on edges that are multiples of TD.
    int e, kd1, kd2, lvl, run_active, run_start, press_edge;
    int m_pt, m_pv, m_press, m_rel, m_long;
    int cyc_no = 0;
    int n_press, n_rel, n_long, last_press_cyc, last_long_cyc;

    function automatic int ticks_in(input int a, input int b);
        return b / TD - a / TD;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        e = 0; kd1 = 0; kd2 = 0; lvl = 0; run_active = 0; run_start = 0; press_edge = 0;
        m_pt = 0; m_pv = 0; m_press = 0; m_rel = 0; m_long = 0;
    endtask

    task automatic model_edge();
        int ks;
        int held;
        ks  = kd2;
        kd2 = kd1;
        kd1 = int'(key);
        e++;
        m_press = 0;
        m_rel   = 0;
        m_long  = 0;
        if (lvl == 1 && (e % TD) == 0 && ticks_in(press_edge, e) == LT) m_long = 1;
        if (ks != lvl) begin
            if (run_active == 0) begin
                run_active = 1;
                run_start  = e;
            end
            if (ticks_in(run_start, e) == DB) begin
                run_active = 0;
                if (lvl == 0) begin
                    lvl        = 1;
                    m_press    = 1;
                    press_edge = e;
                end else begin
                    lvl   = 0;
                    m_rel = 1;
                    held  = ticks_in(press_edge, e);
                    m_pt  = (held > 255) ? 255 : held;
                    m_pv  = 1;
                end
            end
        end else begin
            run_active = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_no++;
        check("key_level", key_level, lvl);
        check("key_press", key_press, m_press);
        check("key_release", key_release, m_rel);
        check("key_long", key_long, m_long);
        check("press_ticks", press_ticks, m_pt);
        check("press_valid", press_valid, m_pv);
        if (key_press) begin n_press++; last_press_cyc = cyc_no; end
        if (key_release) n_rel++;
        if (key_long) begin n_long++; last_long_cyc = cyc_no; end
    endtask

    task automatic run(input logic k, input int n);
        key = k;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_counts();
        n_press = 0;
        n_rel   = 0;
        n_long  = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        tbl[0] = '{1'b0, 20, 0, 0, 0, 1'b0, 0};
        tbl[1] = '{1'b1, 20, 1, 0, 0, 1'b1, 0};
        tbl[2] = '{1'b0, 20, 0, 1, 0, 1'b0, 4};
        tbl[3] = '{1'b1, 60, 1, 0, 1, 1'b1, 0};
        tbl[4] = '{1'b0, 20, 0, 1, 0, 1'b0, 11};
        tbl[5] = '{1'b1,  4, 0, 0, 0, 1'b0, 0};
        tbl[6] = '{1'b0, 20, 0, 0, 0, 1'b0, 0};

        rst_n = 1'b0;
        key   = 1'b1;
        model_reset();
        clear_counts();
        last_press_cyc = 0;
        last_long_cyc  = 0;
        repeat (3) @(negedge clk);
        check("rst_key_level", key_level, 0);
        check("rst_key_press", key_press, 0);
        check("rst_key_release", key_release, 0);
        check("rst_key_long", key_long, 0);
        check("rst_press_ticks", press_ticks, 0);
        check("rst_press_valid", press_valid, 0);

        rst_n = 1'b1;
        c0 = cyc_no;
        run(1'b1, 20);
        check("rst_press_count", n_press, 1);
        check("rst_press_within_14", (last_press_cyc - c0) <= 14, 1);
        run(1'b0, 20);

        for (int i = 0; i < 7; i++) begin
            clear_counts();
            run(tbl[i].k, tbl[i].cycles);
            check($sformatf("vec%0d_press_cnt", i), n_press, tbl[i].np);
            check($sformatf("vec%0d_release_cnt", i), n_rel, tbl[i].nr);
            check($sformatf("vec%0d_long_cnt", i), n_long, tbl[i].nl);
            check($sformatf("vec%0d_level", i), key_level, tbl[i].lvl_end);
            if (tbl[i].min_pt > 0) begin
                check($sformatf("vec%0d_press_ticks_min", i), press_ticks >= DW'(tbl[i].min_pt), 1);
                check($sformatf("vec%0d_press_valid", i), press_valid, 1);
            end
        end
        check("long_gap_cycles", last_long_cyc - last_press_cyc, 32);

        clear_counts();
        for (int i = 0; i < 5; i++) begin
            run(1'b1, 3);
            run(1'b0, 3);
        end
        check("bounce_no_press", n_press, 0);
        check("bounce_no_release", n_rel, 0);
        key = 1'b1;
        c0  = cyc_no;
        n   = 0;
        while (n_press == 0 && n < 20) begin
            cycle();
            n++;
        end
        check("bounce_press_seen", n_press, 1);
        check("bounce_latency_in_range", (n >= 12) && (n <= 15), 1);
        run(1'b1, 10);
        run(1'b0, 20);
        check("bounce_single_press", n_press, 1);

        clear_counts();
        run(1'b1, 20);
        run(1'b0, 2);
        run(1'b1, 60);
        check("relbounce_no_release", n_rel, 0);
        check("relbounce_level", key_level, 1);
        check("relbounce_long_once", n_long, 1);
        run(1'b0, 20);
        check("relbounce_final_release", n_rel, 1);
        check("relbounce_long_total", n_long, 1);

        for (int i = 0; i < 150; i++) run(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
        run(1'b0, 20);

        run(1'b1, (256 + 50) * TD);
        run(1'b0, 20);
        check("sat_press_ticks", press_ticks, 255);
        check("sat_press_valid", press_valid, 1);

        run(1'b1, 30);
        check("midpress_level", key_level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_key_level", key_level, 0);
        check("async_key_press", key_press, 0);
        check("async_key_release", key_release, 0);
        check("async_key_long", key_long, 0);
        check("async_press_ticks", press_ticks, 0);
        check("async_press_valid", press_valid, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        run(1'b1, 20);
        check("post_rst_press", n_press, 1);
        check("post_rst_level", key_level, 1);
        run(1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
